// File: rtl/imem_uart_loader_pkg.sv
// Shared types and helpers for the UART instruction-memory loader.
// Holds the sync byte, FSM encodings and the baud divider calculation.
package imem_uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERR
    } ldr_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Rounded clock cycles per UART bit.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, glitch-rejecting start bit.
// Latency: byte_valid/ferr pulse one cycle after the stop-bit sample.
// Backpressure: none; each byte is a single-cycle pulse that must be consumed.
module imem_uart_loader_uart_rx
    import imem_uart_loader_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       ferr
);

    localparam int CW   = $clog2(DIV + 1);
    localparam int HALF = (DIV / 2 > 0) ? DIV / 2 : 1;

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shreg, sh_nxt;
    logic            vld_nxt, ferr_nxt;

    assign byte_data = shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            rx_meta    <= rx_pin;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_nxt;
            shreg      <= sh_nxt;
            byte_valid <= vld_nxt;
            ferr       <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        vld_nxt   = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_sync) state_nxt = RX_START;
            end
            RX_START: begin
                // A line that is high again at half-bit was only a glitch.
                if (cnt == CW'(HALF - 1)) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rx_sync, shreg[7:1]};
                    bit_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = RX_IDLE;
                    vld_nxt   = rx_sync;
                    ferr_nxt  = !rx_sync;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Framed UART program loader driving the instruction-memory write port; holds the CPU during loads.
// Latency: each word is written the cycle after its 4th byte's byte_valid.
// Backpressure: none; memory write port always accepts, UART input cannot be stalled.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 16 * calc_div(CLK_HZ, BAUD) * 10
) (
    input  logic              sys_clk_in,
    input  logic              sys_rst,
    input  logic              uart_rx_pin,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    logic       byte_valid, ferr;
    logic [7:0] byte_data;

    imem_uart_loader_uart_rx #(.DIV(DIV)) u_rx (
        .clk        (sys_clk_in),
        .rst        (sys_rst),
        .rx_pin     (uart_rx_pin),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .ferr       (ferr)
    );

    ldr_state_t        state, state_nxt;
    logic [CW-1:0]     n_words, n_nxt, wc_nxt;
    logic [1:0]        byte_idx, bidx_nxt;
    logic [31:0]       asm_word, asm_nxt, dina_nxt;
    logic [7:0]        csum, csum_nxt;
    logic [TW-1:0]     tmo, tmo_nxt;
    logic [ADDR_W-1:0] addra_nxt;
    logic              wea_nxt, hold_nxt, done_nxt, err_nxt, go_err;

    always_ff @(posedge sys_clk_in) begin
        if (sys_rst) begin
            state     <= IDLE;
            n_words   <= '0;
            byte_idx  <= '0;
            asm_word  <= '0;
            csum      <= '0;
            tmo       <= '0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            n_words   <= n_nxt;
            byte_idx  <= bidx_nxt;
            asm_word  <= asm_nxt;
            csum      <= csum_nxt;
            tmo       <= tmo_nxt;
            wea       <= wea_nxt;
            addra     <= addra_nxt;
            dina      <= dina_nxt;
            cpu_hold  <= hold_nxt;
            load_done <= done_nxt;
            load_err  <= err_nxt;
            word_cnt  <= wc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n_words;
        bidx_nxt  = byte_idx;
        asm_nxt   = asm_word;
        csum_nxt  = csum;
        tmo_nxt   = tmo;
        wea_nxt   = 1'b0;
        addra_nxt = addra;
        dina_nxt  = dina;
        hold_nxt  = cpu_hold;
        done_nxt  = load_done;
        err_nxt   = load_err;
        wc_nxt    = word_cnt;
        go_err    = 1'b0;

        // Inter-byte watchdog; an arriving byte always beats expiry.
        if (state == COUNT || state == DATA || state == CHECK) begin
            if (byte_valid) tmo_nxt = '0;
            else if (tmo == TW'(TIMEOUT_CYC - 1)) go_err = 1'b1;
            else tmo_nxt = tmo + TW'(1);
            if (ferr) go_err = 1'b1;
        end

        case (state)
            IDLE, DONE, ERR: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_nxt = COUNT;
                    hold_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    wc_nxt    = '0;
                    tmo_nxt   = '0;
                end
            end
            COUNT: begin
                if (byte_valid) begin
                    if (byte_data == 8'd0 || int'(byte_data) > DEPTH) begin
                        go_err = 1'b1;
                    end else begin
                        n_nxt     = CW'(byte_data);
                        csum_nxt  = byte_data;
                        bidx_nxt  = '0;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_valid) begin
                    // Little-endian: the first byte drifts down to bits [7:0].
                    asm_nxt  = {byte_data, asm_word[31:8]};
                    csum_nxt = csum ^ byte_data;
                    bidx_nxt = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        wea_nxt   = 1'b1;
                        addra_nxt = word_cnt[ADDR_W-1:0];
                        dina_nxt  = {byte_data, asm_word[31:8]};
                        wc_nxt    = word_cnt + CW'(1);
                        if (word_cnt + CW'(1) == n_words) state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (byte_valid) begin
                    if (byte_data == csum) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        hold_nxt  = 1'b0;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (go_err) begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
            hold_nxt  = 1'b1;
        end
    end

endmodule
